// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word and sends it LSB first,
// each bit held CLKS_PER_BIT cycles. Optional even-parity bit when PARITY_EN is defined.
`timescale 1ns/1ps

module piso_shift_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp,
  output logic             serial_out,
  output logic [1:0]       sel_out,
  output logic             busy,
  output logic             done,
  output logic             par_valid
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] SEL_SHIFT = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b00;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             bit_end;
`ifdef PARITY_EN
  logic             par_bit;
`endif

  assign bit_end = (cyc_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is a datapath register but is reset anyway so that
      // an aborted word leaves no residue visible on serial_out.
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      cyc_cnt   <= '0;
`ifdef PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shift_reg <= inp;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
`ifdef PARITY_EN
            par_bit   <= ^inp;
`endif
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bit_end) begin
            cyc_cnt   <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_DONE;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end

`ifdef PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= ST_DONE;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
`endif

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state, so reset forces them without a clock.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    serial_out = 1'b0;
    sel_out    = SEL_HOLD;
    par_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SHIFT: begin
        serial_out = shift_reg[0];
        sel_out    = bit_end ? SEL_SHIFT : SEL_HOLD;
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        serial_out = par_bit;
        par_valid  = 1'b1;
      end
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: two instances (CLKS_PER_BIT 1 and 3) checked
// cycle by cycle against a per-word expected waveform; honours PARITY_EN if defined.
`timescale 1ns/1ps

module tb_piso_shift_tx;

  localparam int W = 4;

  typedef struct packed {
    logic       ready;
    logic       serial;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       par;
  } obs_t;

  localparam obs_t IDLE_OBS = '{ready: 1'b1, serial: 1'b0, sel: 2'b00,
                                busy: 1'b0, done: 1'b0, par: 1'b0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         use3 = 1'b0;
  logic [W-1:0] inp = '0;

  always #5 clk = ~clk;

  logic       iv1, iv3;
  logic       rdy1, ser1, busy1, done1, par1;
  logic       rdy3, ser3, busy3, done3, par3;
  logic [1:0] sel1, sel3;

  assign iv1 = in_valid & ~use3;
  assign iv3 = in_valid & use3;

  piso_shift_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1), .inp(inp),
    .serial_out(ser1), .sel_out(sel1), .busy(busy1), .done(done1), .par_valid(par1)
  );

  piso_shift_tx #(.WIDTH(W), .CLKS_PER_BIT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(rdy3), .inp(inp),
    .serial_out(ser3), .sel_out(sel3), .busy(busy3), .done(done3), .par_valid(par3)
  );

  obs_t obs1, obs3, obs;
  always_comb begin
    obs1 = '{ready: rdy1, serial: ser1, sel: sel1, busy: busy1, done: done1, par: par1};
    obs3 = '{ready: rdy3, serial: ser3, sel: sel3, busy: busy3, done: done3, par: par3};
    obs  = use3 ? obs3 : obs1;
  end

  // Loopback receiver: shifts right, serial bit enters at the MSB on sel=2'b10.
  logic [W-1:0] rx = '0;
  always @(posedge clk) if (obs.sel == 2'b10) rx <= {obs.serial, rx[W-1:1]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_total = 0;
  obs_t exp_q[$];

  // Expected per-cycle waveform for one word, starting the cycle after the transfer
  // and ending with the first IDLE cycle after DONE.
  function automatic void build_model(input logic [W-1:0] w, input int cpb);
    exp_q.delete();
    for (int b = 0; b < W; b++)
      for (int c = 0; c < cpb; c++)
        exp_q.push_back('{ready: 1'b0, serial: w[b], sel: (c == cpb - 1) ? 2'b10 : 2'b00,
                          busy: 1'b1, done: 1'b0, par: 1'b0});
`ifdef PARITY_EN
    for (int c = 0; c < cpb; c++)
      exp_q.push_back('{ready: 1'b0, serial: ^w, sel: 2'b00,
                        busy: 1'b1, done: 1'b0, par: 1'b1});
`endif
    exp_q.push_back('{ready: 1'b0, serial: 1'b0, sel: 2'b00, busy: 1'b1, done: 1'b1, par: 1'b0});
    exp_q.push_back(IDLE_OBS);
  endfunction

  function automatic int word_period(input int cpb);
    int p;
    p = W * cpb + 2;
`ifdef PARITY_EN
    p = p + cpb;
`endif
    return p;
  endfunction

  // Called at a negedge with the selected DUT idle; returns at the first IDLE negedge.
  task automatic send_word(input logic [W-1:0] w, input bit on3, input bit hold_valid,
                           output int t_xfer);
    int cpb;
    cpb      = on3 ? 3 : 1;
    use3     = on3;
    in_valid = 1'b1;
    inp      = w;
    #1;
    n_total++;
    if (obs.ready !== 1'b1)
      $display("FAIL accept_ready word=%b got=%b expected=1", w, obs.ready);
    else n_pass++;
    @(posedge clk);
    t_xfer = cyc;
    build_model(w, cpb);
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      in_valid = hold_valid;
      inp      = W'($urandom);
      #1;
      n_total++;
      if (obs !== exp_q[i])
        $display("FAIL wave word=%b cpb=%0d step=%0d got=%b expected=%b",
                 w, cpb, i, obs, exp_q[i]);
      else n_pass++;
      if (exp_q[i].done) begin
        n_total++;
        if (rx !== w) $display("FAIL loopback got=%b expected=%b", rx, w);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    n_total++;
    if (obs1 !== IDLE_OBS) $display("FAIL reset_dut1 got=%b expected=%b", obs1, IDLE_OBS);
    else n_pass++;
    n_total++;
    if (obs3 !== IDLE_OBS) $display("FAIL reset_dut3 got=%b expected=%b", obs3, IDLE_OBS);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t;
    send_word(4'b1011, 1'b0, 1'b0, t);
    for (int k = 0; k < 6; k++) send_word(W'($urandom), 1'b0, 1'b0, t);
  endtask

  task automatic test_slow_bits();
    int t;
    send_word(4'b0110, 1'b1, 1'b0, t);
    for (int k = 0; k < 3; k++) send_word(W'($urandom), 1'b1, 1'b0, t);
  endtask

  task automatic test_parity_word();
    int t;
    send_word(4'b0111, 1'b0, 1'b0, t);
    send_word(4'b0111, 1'b1, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3;
    send_word(W'($urandom), 1'b0, 1'b1, t1);
    send_word(W'($urandom), 1'b0, 1'b1, t2);
    send_word(W'($urandom), 1'b0, 1'b0, t3);
    n_total++;
    if (t2 - t1 !== word_period(1))
      $display("FAIL period_1 got=%0d expected=%0d", t2 - t1, word_period(1));
    else n_pass++;
    n_total++;
    if (t3 - t2 !== word_period(1))
      $display("FAIL period_2 got=%0d expected=%0d", t3 - t2, word_period(1));
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    int t;
    use3     = 1'b0;
    in_valid = 1'b1;
    inp      = 4'b1101;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (obs !== IDLE_OBS) $display("FAIL reset_async got=%b expected=%b", obs, IDLE_OBS);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++;
      if (obs !== IDLE_OBS) $display("FAIL reset_hold k=%0d got=%b expected=%b", k, obs, IDLE_OBS);
      else n_pass++;
    end
    reset = 1'b1;
    send_word(W'($urandom), 1'b0, 1'b0, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_slow_bits();
    test_parity_word();
    test_back_to_back();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 SHALL have parameter: WIDTH, 4, data word width in bits (legal range 2..16).
REQ-002 SHALL have parameter: CLKS_PER_BIT, 1, clk cycles per serial bit (legal range 1..256).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  parallel word offered.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: inp  input  WIDTH  parallel word to serialize.
REQ-008 SHALL have port: serial_out  output  1  serial data bit, LSB first.
REQ-009 SHALL have port: sel_out  output  2  receiver shift-register control: 2'b10 = shift right, 2'b00 = hold.
REQ-010 SHALL have port: busy  output  1  word in flight (SHIFT, PARITY or DONE state).
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last bit of a word.
REQ-012 SHALL have port: par_valid  output  1  serial_out carries the parity bit (always 0 when PARITY_EN is undefined).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, PARITY, DONE; PARITY exists only when PARITY_EN is defined.
REQ-014 SHALL drive in_ready=1 only in IDLE; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-015 SHALL, on transfer, latch inp into an internal WIDTH-bit shift register, clear the bit and cycle counters, and go to SHIFT.
REQ-016 SHALL, in SHIFT, drive serial_out = shift_reg[0], holding each bit for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL drive sel_out=2'b10 only on the last cycle of each data-bit period, and 2'b00 in every other cycle and state.
REQ-018 SHALL shift the internal register right by one at the end of each bit period; the bit counter counts 0..WIDTH-1.
REQ-019 SHALL, after bit WIDTH-1 completes, go to PARITY if PARITY_EN is defined, otherwise to DONE.
REQ-020 SHALL, in PARITY, drive serial_out = XOR of the latched word (even parity), par_valid=1 and sel_out=2'b00 for CLKS_PER_BIT cycles, then go to DONE.
REQ-021 SHALL, in DONE, hold done=1 and serial_out=0 for exactly one cycle, then return to IDLE.
REQ-022 SHALL ignore inp and in_valid while not in IDLE; inp changes after the transfer do not affect the word in flight.
REQ-023 SHALL hold serial_out=0 and sel_out=2'b00 in IDLE.
REQ-024 SHALL give a word-to-word period of WIDTH*CLKS_PER_BIT + 2 cycles (+CLKS_PER_BIT with PARITY_EN) under continuous in_valid.
REQ-025 SHALL treat in_valid=1 during DONE as not accepted; it is accepted on the following IDLE cycle.

Reset
REQ-026 SHALL, while reset=0, immediately force: state IDLE, in_ready=1, serial_out=0, sel_out=2'b00, busy=0, done=0, par_valid=0, counters and shift register 0.
REQ-027 SHALL abort any word in flight on reset assertion, with no done pulse; the first rising clk edge after reset deassertion is a normal IDLE cycle.

Configuration
REQ-028 SHALL, with macro PIPO_PARITY_EN... renamed below; macro name is PARITY_EN: when defined, append one even-parity bit per word per REQ-020.
REQ-029 SHALL, with PARITY_EN undefined, omit the PARITY state and tie par_valid to 0; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: WIDTH=4, CLKS_PER_BIT=1, inp=4'b1011 accepted -> serial_out 1,1,0,1 over 4 cycles, sel_out=2'b10 each cycle, done pulses on the 5th cycle.
REQ-031 SHALL cover: CLKS_PER_BIT=3, inp=4'b0110 -> each bit held 3 cycles, sel_out=2'b10 only on cycles 3,6,9,12 after transfer.
REQ-032 SHALL cover: PARITY_EN defined, inp=4'b0111 -> 4 data bits, then serial_out=1 with par_valid=1 and sel_out=2'b00 for one bit period, then done.
REQ-033 SHALL cover: in_valid held high, inp changed mid-word -> in_ready=0 until IDLE; second word starts exactly 6 cycles after the first (WIDTH=4, CLKS_PER_BIT=1, no parity).
REQ-034 SHALL cover: reset=0 asserted during bit 2 -> outputs reach reset values without a clock edge, no done pulse, and a new word is accepted on the first edge after release.
REQ-035 SHALL cover: loopback into a 4-bit receiver register shifting right with serial_out into its MSB on sel_out=2'b10 -> receiver holds 4'b1011 when done pulses.
